ifu_fetch_ctrl: RTL and testbench

- Instruction-fetch initiator for the single-cycle MIPS core. Sits between the instruction ROM (10-bit word address in, 32-bit instruction out, combinational read) and the decoder.
- Owns the PC register, drives the ROM read address and selects the next PC: sequential, branch, jump or register jump.
- Traps illegal fetch targets into a sticky halt state and counts retired fetches.

---
 rtl/ifu_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction-fetch initiator for the single-cycle MIPS core.
// Owns the PC, drives the combinational ROM word address and selects the next
// PC (sequential, branch, jump, register jump). A fetch target outside the
// ROM window, or one that is not word aligned, traps the block into a sticky
// HALT state that only reset leaves. Retired fetches are counted.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   stall                 hold the PC this cycle
//   npc_sel[1:0]          0 = PC+4, 1 = branch, 2 = jump, 3 = register jump
//   branch_taken, imm16   branch condition and word offset
//   instr_index[25:0]     j/jal target field
//   jr_target[31:0]       jr target
//   im_addr[9:0]          ROM word address (zero-cycle read)
//   im_data[31:0]         ROM read data
//   instr[31:0]           instruction to decoder (nop while halted)
//   pc, pc_plus4          current PC and PC+4 (jal linkage)
//   halted, err_pc        trap flag and offending target
//   fetch_count           PC advances since reset
//
// state  | meaning
// S_RUN  | fetching; PC advances on every unstalled cycle with a legal target
// S_HALT | illegal target seen; everything frozen until reset
module ifu_fetch_ctrl #(
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [31:0] err_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  // One past the last legal byte; 33 bits so a window ending at 2^32 still works.
  localparam logic [32:0] PC_END = {1'b0, PC_BASE} + 33'(4 * IM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic        npc_legal;

  assign pc_plus4_w = pc_q + 32'd4;
  assign br_off     = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = pc_plus4_w;
    unique case (npc_sel)
      2'd0: npc = pc_plus4_w;
      2'd1: npc = branch_taken ? (pc_plus4_w + br_off) : pc_plus4_w;
      // Upper nibble comes from pc itself, not pc+4.
      2'd2: npc = {pc_q[31:28], instr_index, 2'b00};
      2'd3: npc = jr_target;
      default: npc = pc_plus4_w;
    endcase
  end

  assign npc_legal = (npc[1:0] == 2'b00) && (npc >= PC_BASE) &&
                     ({1'b0, npc} < PC_END);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_pc_d = err_pc_q;
    count_d  = count_q;
    unique case (state_q)
      S_RUN: begin
        // A stalled cycle never traps, even if the candidate is bad.
        if (!stall) begin
          if (npc_legal) begin
            pc_d    = npc;
            count_d = count_q + 32'd1;
          end else begin
            state_d  = S_HALT;
            err_pc_d = npc;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= PC_BASE;
      err_pc_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_pc_q <= err_pc_d;
      count_q  <= count_d;
    end
  end

  // Truncating cast picks byte-offset bits [11:2] as the word address.
  assign im_addr     = 10'((pc_q - PC_BASE) >> 2);
  assign instr       = (state_q == S_RUN) ? im_data : 32'h0;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign halted      = (state_q == S_HALT);
  assign err_pc      = err_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'd0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] jr_target = 32'd0;
  logic [9:0]  im_addr;
  logic [31:0] im_data = 32'd0;
  logic [31:0] instr, pc, pc_plus4, err_pc, fetch_count;
  logic        halted;

  ifu_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .branch_taken(branch_taken), .imm16(imm16), .instr_index(instr_index),
    .jr_target(jr_target), .im_addr(im_addr), .im_data(im_data),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .halted(halted),
    .err_pc(err_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] im_addr;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] halted;
    logic [31:0] err_pc;
    logic [31:0] count;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state
  logic [31:0] m_pc, m_err, m_cnt;
  bit          m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
    else n_pass++;
  endtask

  // Monitor: compares whatever the driver queued against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",          pc,                 e.pc);
        chk("im_addr",     {22'd0, im_addr},   e.im_addr);
        chk("instr",       instr,              e.instr);
        chk("pc_plus4",    pc_plus4,           e.pc_plus4);
        chk("halted",      {31'd0, halted},    e.halted);
        chk("err_pc",      err_pc,             e.err_pc);
        chk("fetch_count", fetch_count,        e.count);
      end
    end
  end

  function automatic logic [31:0] model_npc();
    logic [31:0] t;
    case (npc_sel)
      2'd0: t = m_pc + 4;
      2'd1: t = branch_taken ? m_pc + 4 + 32'($signed(imm16)) * 4 : m_pc + 4;
      2'd2: t = (m_pc & 32'hF000_0000) + {6'd0, instr_index} * 4;
      default: t = jr_target;
    endcase
    return t;
  endfunction

  function automatic bit model_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= BASE) && ({1'b0, a} < {1'b0, BASE} + 33'(4 * WORDS));
  endfunction

  // Called at posedge+1 with inputs already set for this cycle.
  task automatic step(input bit st, input logic [1:0] sel, input bit bt,
                      input logic [15:0] imm, input logic [25:0] idx,
                      input logic [31:0] jr);
    exp_t e;
    logic [31:0] n;
    stall = st; npc_sel = sel; branch_taken = bt; imm16 = imm;
    instr_index = idx; jr_target = jr; im_data = $urandom;
    #1;
    e.pc       = m_pc;
    e.im_addr  = (m_pc - BASE) / 4;
    e.instr    = m_halt ? 32'h0 : im_data;
    e.pc_plus4 = m_pc + 4;
    e.halted   = {31'd0, m_halt};
    e.err_pc   = m_err;
    e.count    = m_cnt;
    q.push_back(e);
    @(posedge clk);
    if (!m_halt && !st) begin
      n = model_npc();
      if (model_legal(n)) begin
        m_pc  = n;
        m_cnt = m_cnt + 1;
      end else begin
        m_halt = 1'b1;
        m_err  = n;
      end
    end
    #1;
  endtask

  // Reset pulse placed between clock edges; effect must be immediate.
  task automatic do_reset();
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    m_pc = BASE; m_err = 32'd0; m_cnt = 32'd0; m_halt = 1'b0;
    chk("rst_pc",      pc,          BASE);
    chk("rst_halted",  {31'd0, halted}, 32'd0);
    chk("rst_count",   fetch_count, 32'd0);
    chk("rst_err_pc",  err_pc,      32'd0);
    chk("rst_im_addr", {22'd0, im_addr}, 32'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic jr_to(input logic [31:0] a);
    step(0, 2'd3, 0, 16'd0, 26'd0, a);
  endtask

  initial begin
    m_pc = BASE; m_err = 0; m_cnt = 0; m_halt = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Sequential fetch
    repeat (4) step(0, 2'd0, 0, 16'd0, 26'd0, 32'd0);
    // Branch back, not taken, and self-loop from 3010
    step(0, 2'd1, 1, 16'hFFFC, 26'd0, 32'd0);
    jr_to(32'h3010);
    step(0, 2'd1, 0, 16'hFFFC, 26'd0, 32'd0);
    jr_to(32'h3010);
    step(0, 2'd1, 1, 16'hFFFF, 26'd0, 32'd0);
    step(0, 2'd1, 1, 16'hFFFF, 26'd0, 32'd0);
    // Jump and register jump
    jr_to(32'h3000);
    step(0, 2'd2, 0, 16'd0, 26'h0000C05, 32'd0);
    step(0, 2'd3, 0, 16'd0, 26'd0, 32'h3008);
    // Stalled bad target is ignored, then traps when stall drops
    repeat (4) step(1, 2'd3, 0, 16'd0, 26'd0, 32'd0);
    step(0, 2'd3, 0, 16'd0, 26'd0, 32'd0);
    // Halted: random inputs change nothing
    repeat (5) step($urandom_range(0, 1), 2'($urandom), 1'($urandom), 16'($urandom),
                    26'($urandom), $urandom);
    do_reset();

    // Run off the end of ROM
    jr_to(32'h3FFC);
    step(0, 2'd0, 0, 16'd0, 26'd0, 32'd0);
    step(0, 2'd0, 0, 16'd0, 26'd0, 32'd0);
    do_reset();
    // Misaligned register jump
    jr_to(32'h3002);
    step(0, 2'd0, 0, 16'd0, 26'd0, 32'd0);
    do_reset();

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jr;
      logic [25:0] idx;
      int          off;
      jr  = ($urandom_range(0, 7) == 0) ? $urandom
                                        : BASE + 4 * $urandom_range(0, WORDS - 1);
      idx = ($urandom_range(0, 7) == 0) ? 26'($urandom)
                                        : 26'h0000C00 + 26'($urandom_range(0, WORDS - 1));
      off = int'($urandom_range(0, 40)) - 20;
      step($urandom_range(0, 3) == 0, 2'($urandom), 1'($urandom), 16'(off), idx, jr);
      if (m_halt && $urandom_range(0, 2) == 0) do_reset();
    end

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
